// File: rtl/i2c_slave_pkg.sv
// Shared definitions for the I2C slave byte receiver.
//   state_t           : receiver FSM states
//   BYTE_W            : bits per I2C transfer
//   ADDR_W            : I2C slave address width (7-bit addressing only)
//   GENERAL_CALL_ADDR : reserved general-call address
package i2c_slave_pkg;

    localparam int unsigned   BYTE_W            = 8;
    localparam int unsigned   ADDR_W            = 7;
    localparam logic [6:0]    GENERAL_CALL_ADDR = 7'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_HANDOFF,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/i2c_slave_byte_receiver_shifter.sv
// i2c_bit_shifter: MSB-first 8-bit shift register with a 3-bit bit counter.
//   CLK       in   SCL, all updates on posedge
//   RST       in   asynchronous active-low reset
//   sda       in   sampled SDA
//   load      in   first bit after START: shift <= {7'b0, sda}, bit_cnt <= 1
//   clear     in   restart framing: shift <= 0, bit_cnt <= 0
//   shift_en  in   shift sda in and advance bit_cnt
//   next_byte out  value the register holds after the current shift
//   byte_done out  current shift completes a byte (bit_cnt == 7 while shifting)
module i2c_bit_shifter
    import i2c_slave_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              sda,
    input  logic              load,
    input  logic              clear,
    input  logic              shift_en,
    output logic [BYTE_W-1:0] next_byte,
    output logic              byte_done
);

    logic [BYTE_W-1:0] shift_q;
    logic [2:0]        bit_cnt;

    assign next_byte = {shift_q[BYTE_W-2:0], sda};
    assign byte_done = shift_en && (bit_cnt == 3'd7);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shift_q <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            shift_q <= {{(BYTE_W-1){1'b0}}, sda};
            bit_cnt <= 3'd1;
        end else if (clear) begin
            shift_q <= '0;
            bit_cnt <= '0;
        end else if (shift_en) begin
            shift_q <= next_byte;
            // 3-bit counter wraps 7 -> 0 on the byte-completing edge
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

endmodule

// File: rtl/i2c_slave_byte_receiver.sv
// I2C slave byte receiver, clocked by SCL. Frames address and write-data
// bytes, drives the ACK generator handshake and hands write bytes to the
// application side.
//   CLK        in   SCL
//   RST        in   asynchronous active-low reset
//   SDA_in     in   sampled SDA
//   start_det  in   START / repeated START until the first SCL rising edge
//   stop_det   in   STOP detected
//   done_ack   in   ACK generator finished the ACK bit
//   rx_ready   in   application can accept a data byte
//   ack_enable out  ACK generator enable
//   ack_cond   out  ACK generator acknowledgement condition
//   nack_cond  out  ACK generator not-acknowledgement condition
//   addr_match out  slave addressed in the current transaction
//   rw_bit     out  captured R/W bit (1 = master read)
//   rx_data    out  last received write byte
//   rx_valid   out  one-cycle pulse when rx_data updates
//   busy       out  FSM not idle
// Build option: I2C_SLAVE_GENERAL_CALL_EN accepts address 7'h00 + W.
module i2c_slave_byte_receiver #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h50,
    parameter int unsigned ADDR_W     = 7
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SDA_in,
    input  logic       start_det,
    input  logic       stop_det,
    input  logic       done_ack,
    input  logic       rx_ready,
    output logic       ack_enable,
    output logic       ack_cond,
    output logic       nack_cond,
    output logic       addr_match,
    output logic       rw_bit,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy
);

    import i2c_slave_pkg::*;

    state_t            state, state_d;
    logic              ack_enable_d, ack_cond_d, nack_cond_d;
    logic              addr_match_d, rw_bit_d, rx_valid_d;
    logic [7:0]        rx_data_d;

    logic              sh_load, sh_clear, sh_shift;
    logic [BYTE_W-1:0] next_byte;
    logic              byte_done;
    logic [ADDR_W-1:0] rx_addr;
    logic              addr_hit;

    i2c_bit_shifter u_shifter (
        .CLK       (CLK),
        .RST       (RST),
        .sda       (SDA_in),
        .load      (sh_load),
        .clear     (sh_clear),
        .shift_en  (sh_shift),
        .next_byte (next_byte),
        .byte_done (byte_done)
    );

    // On the 8th address edge SDA_in is the R/W bit, so the address sits
    // in the upper seven bits of the completed byte.
    assign rx_addr = next_byte[BYTE_W-1 -: ADDR_W];

    always_comb begin
`ifdef I2C_SLAVE_GENERAL_CALL_EN
        addr_hit = (rx_addr == SLAVE_ADDR) ||
                   ((rx_addr == GENERAL_CALL_ADDR) && !SDA_in);
`else
        addr_hit = (rx_addr == SLAVE_ADDR);
`endif
    end

    assign busy = (state != ST_IDLE);

    always_comb begin
        state_d      = state;
        ack_enable_d = ack_enable;
        ack_cond_d   = ack_cond;
        nack_cond_d  = nack_cond;
        addr_match_d = addr_match;
        rw_bit_d     = rw_bit;
        rx_data_d    = rx_data;
        rx_valid_d   = 1'b0;
        sh_load      = 1'b0;
        sh_clear     = 1'b0;
        sh_shift     = 1'b0;

        if (stop_det) begin
            state_d      = ST_IDLE;
            ack_enable_d = 1'b0;
            ack_cond_d   = 1'b0;
            nack_cond_d  = 1'b0;
            addr_match_d = 1'b0;
            rw_bit_d     = 1'b0;
        end else if (start_det) begin
            // START edge also carries the address MSB
            sh_load      = 1'b1;
            state_d      = ST_ADDR;
            ack_enable_d = 1'b0;
            ack_cond_d   = 1'b0;
            nack_cond_d  = 1'b0;
            addr_match_d = 1'b0;
            rw_bit_d     = 1'b0;
        end else begin
            unique case (state)
                ST_ADDR: begin
                    sh_shift = 1'b1;
                    if (byte_done) begin
                        if (addr_hit) begin
                            addr_match_d = 1'b1;
                            rw_bit_d     = SDA_in;
                            ack_enable_d = 1'b1;
                            ack_cond_d   = 1'b1;
                            nack_cond_d  = 1'b0;
                            state_d      = ST_ADDR_ACK;
                        end else begin
                            state_d      = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (done_ack) begin
                        ack_enable_d = 1'b0;
                        ack_cond_d   = 1'b0;
                        nack_cond_d  = 1'b0;
                        sh_clear     = 1'b1;
                        state_d      = rw_bit ? ST_HANDOFF : ST_DATA;
                    end
                end
                ST_DATA: begin
                    sh_shift = 1'b1;
                    if (byte_done) begin
                        rx_data_d    = next_byte;
                        rx_valid_d   = 1'b1;
                        ack_enable_d = 1'b1;
                        ack_cond_d   = rx_ready;
                        nack_cond_d  = !rx_ready;
                        state_d      = ST_DATA_ACK;
                    end
                end
                ST_DATA_ACK: begin
                    if (done_ack) begin
                        ack_enable_d = 1'b0;
                        ack_cond_d   = 1'b0;
                        nack_cond_d  = 1'b0;
                        if (ack_cond) begin
                            sh_clear = 1'b1;
                            state_d  = ST_DATA;
                        end else begin
                            addr_match_d = 1'b0;
                            state_d      = ST_IGNORE;
                        end
                    end
                end
                default: ; // IDLE, HANDOFF, IGNORE wait for START/STOP
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= ST_IDLE;
            ack_enable <= 1'b0;
            ack_cond   <= 1'b0;
            nack_cond  <= 1'b0;
            addr_match <= 1'b0;
            rw_bit     <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
        end else begin
            state      <= state_d;
            ack_enable <= ack_enable_d;
            ack_cond   <= ack_cond_d;
            nack_cond  <= nack_cond_d;
            addr_match <= addr_match_d;
            rw_bit     <= rw_bit_d;
            rx_data    <= rx_data_d;
            rx_valid   <= rx_valid_d;
        end
    end

endmodule
